mips_alu_issue: RTL

- Decode/issue stage that produces the 5-bit ALU function code and operand-select controls consumed by the ALU.
- Accepts 32-bit MIPS instruction words on a valid/ready interface and decodes them into one registered issue slot.
- Tracks the HI/LO divide latency and stalls mfhi/mflo behind an outstanding div/divu.
- Sits between instruction fetch and the register-read/ALU stage.

---
 rtl/mips_alu_pkg.sv | 97 +++++++++
 rtl/mips_alu_issue_decode.sv | 145 ++++++++++++++
 rtl/mips_alu_issue.sv | 101 ++++++++++
 3 files changed

// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - ALU function codes, MIPS opcode/funct values and decoded-op types
package mips_alu_pkg;

    // ALU function codes, matching the ALU's own encoding
    localparam logic [4:0] FN_SLL  = 5'b00000;
    localparam logic [4:0] FN_SRL  = 5'b00001;
    localparam logic [4:0] FN_SRA  = 5'b00010;
    localparam logic [4:0] FN_MFHI = 5'b00011;
    localparam logic [4:0] FN_MFLO = 5'b00100;
    localparam logic [4:0] FN_MUL  = 5'b00101;
    localparam logic [4:0] FN_DIV  = 5'b00110;
    localparam logic [4:0] FN_DIVU = 5'b00111;
    localparam logic [4:0] FN_ADD  = 5'b01000;
    localparam logic [4:0] FN_ADDU = 5'b01001;
    localparam logic [4:0] FN_SUB  = 5'b01010;
    localparam logic [4:0] FN_SUBU = 5'b01011;
    localparam logic [4:0] FN_AND  = 5'b01100;
    localparam logic [4:0] FN_OR   = 5'b01101;
    localparam logic [4:0] FN_XOR  = 5'b01110;
    localparam logic [4:0] FN_NOR  = 5'b01111;
    localparam logic [4:0] FN_SLT  = 5'b10000;
    localparam logic [4:0] FN_SLTU = 5'b10001;
    localparam logic [4:0] FN_LUI  = 5'b10010;
    localparam logic [4:0] FN_BEQ  = 5'b10011;
    localparam logic [4:0] FN_BNE  = 5'b10101;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    // R-type funct field values
    localparam logic [5:0] RF_SLL  = 6'h00;
    localparam logic [5:0] RF_SRL  = 6'h02;
    localparam logic [5:0] RF_SRA  = 6'h03;
    localparam logic [5:0] RF_SLLV = 6'h04;
    localparam logic [5:0] RF_SRLV = 6'h06;
    localparam logic [5:0] RF_SRAV = 6'h07;
    localparam logic [5:0] RF_MFHI = 6'h10;
    localparam logic [5:0] RF_MFLO = 6'h12;
    localparam logic [5:0] RF_DIV  = 6'h1A;
    localparam logic [5:0] RF_DIVU = 6'h1B;
    localparam logic [5:0] RF_ADD  = 6'h20;
    localparam logic [5:0] RF_ADDU = 6'h21;
    localparam logic [5:0] RF_SUB  = 6'h22;
    localparam logic [5:0] RF_SUBU = 6'h23;
    localparam logic [5:0] RF_AND  = 6'h24;
    localparam logic [5:0] RF_OR   = 6'h25;
    localparam logic [5:0] RF_XOR  = 6'h26;
    localparam logic [5:0] RF_NOR  = 6'h27;
    localparam logic [5:0] RF_SLT  = 6'h2A;
    localparam logic [5:0] RF_SLTU = 6'h2B;

    // SPECIAL2 funct values
    localparam logic [5:0] SF_MUL  = 6'h02;

    typedef enum logic {
        A_RS = 1'b0,
        A_RT = 1'b1
    } a_src_e;

    typedef enum logic [1:0] {
        B_RT  = 2'd0,
        B_IMM = 2'd1,
        B_RS  = 2'd2
    } b_src_e;

    typedef struct packed {
        logic [4:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        a_src_e      a_src;
        b_src_e      b_src;
        logic [31:0] imm;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        branch;
    } dec_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/mips_alu_issue_decode.sv
// rtl/mips_alu_issue_decode.sv - combinational MIPS word to decoded ALU op
module mips_alu_issue_decode
    import mips_alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_op_t     op,
    output logic        illegal,
    output logic        hilo_use,
    output logic        is_div
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign imm16  = instr[15:0];

    // Table decode; r0 destinations never write back
    always_comb begin
        op         = '0;
        op.rs      = instr[25:21];
        op.rt      = instr[20:16];
        op.a_src   = A_RS;
        op.b_src   = B_RT;
        illegal    = 1'b0;
        hilo_use   = 1'b0;
        is_div     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                op.wr_en   = 1'b1;
                op.wr_addr = rd;
                case (funct)
                    RF_SLL: begin
                        op.funct = FN_SLL;
                        op.a_src = A_RT;
                        op.b_src = B_IMM;
                        op.imm   = {27'b0, shamt};
                    end
                    RF_SRL: begin
                        op.funct = FN_SRL;
                        op.a_src = A_RT;
                        op.b_src = B_IMM;
                        op.imm   = {27'b0, shamt};
                    end
                    RF_SRA: begin
                        op.funct = FN_SRA;
                        op.a_src = A_RT;
                        op.b_src = B_IMM;
                        op.imm   = {27'b0, shamt};
                    end
                    RF_SLLV: begin
                        op.funct = FN_SLL;
                        op.a_src = A_RT;
                        op.b_src = B_RS;
                    end
                    RF_SRLV: begin
                        op.funct = FN_SRL;
                        op.a_src = A_RT;
                        op.b_src = B_RS;
                    end
                    RF_SRAV: begin
                        op.funct = FN_SRA;
                        op.a_src = A_RT;
                        op.b_src = B_RS;
                    end
                    RF_MFHI: begin
                        op.funct = FN_MFHI;
                        hilo_use = 1'b1;
                    end
                    RF_MFLO: begin
                        op.funct = FN_MFLO;
                        hilo_use = 1'b1;
                    end
                    RF_DIV: begin
                        op.funct = FN_DIV;
                        op.wr_en = 1'b0;
                        hilo_use = 1'b1;
                        is_div   = 1'b1;
                    end
                    RF_DIVU: begin
                        op.funct = FN_DIVU;
                        op.wr_en = 1'b0;
                        hilo_use = 1'b1;
                        is_div   = 1'b1;
                    end
                    RF_ADD:  op.funct = FN_ADD;
                    RF_ADDU: op.funct = FN_ADDU;
                    RF_SUB:  op.funct = FN_SUB;
                    RF_SUBU: op.funct = FN_SUBU;
                    RF_AND:  op.funct = FN_AND;
                    RF_OR:   op.funct = FN_OR;
                    RF_XOR:  op.funct = FN_XOR;
                    RF_NOR:  op.funct = FN_NOR;
                    RF_SLT:  op.funct = FN_SLT;
                    RF_SLTU: op.funct = FN_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                if (funct == SF_MUL) begin
                    op.funct   = FN_MUL;
                    op.wr_en   = 1'b1;
                    op.wr_addr = rd;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                op.b_src   = B_IMM;
                op.wr_en   = 1'b1;
                op.wr_addr = instr[20:16];
                case (opcode)
                    OP_ADDI:  begin op.funct = FN_ADD;  op.imm = sext16(imm16); end
                    OP_ADDIU: begin op.funct = FN_ADDU; op.imm = sext16(imm16); end
                    OP_SLTI:  begin op.funct = FN_SLT;  op.imm = sext16(imm16); end
                    OP_SLTIU: begin op.funct = FN_SLTU; op.imm = sext16(imm16); end
                    OP_ANDI:  begin op.funct = FN_AND;  op.imm = zext16(imm16); end
                    OP_ORI:   begin op.funct = FN_OR;   op.imm = zext16(imm16); end
                    OP_XORI:  begin op.funct = FN_XOR;  op.imm = zext16(imm16); end
                    default:  begin op.funct = FN_LUI;  op.imm = zext16(imm16); end
                endcase
            end
            OP_BEQ: begin
                op.funct  = FN_BEQ;
                op.branch = 1'b1;
            end
            OP_BNE: begin
                op.funct  = FN_BNE;
                op.branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (op.wr_addr == 5'd0) begin
            op.wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/mips_alu_issue.sv
// rtl/mips_alu_issue.sv - decode/issue slot with HI/LO divide-latency interlock
module mips_alu_issue
    import mips_alu_pkg::*;
#(
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_funct,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic        out_a_src,
    output logic [1:0]  out_b_src,
    output logic [31:0] out_imm,
    output logic        out_wr_en,
    output logic [4:0]  out_wr_addr,
    output logic        out_branch,
    output logic        err_illegal
);

    localparam logic [3:0] DIV_LAT_CNT = 4'(DIV_LAT);

    dec_op_t    dec_op;
    logic       dec_illegal;
    logic       dec_hilo;
    logic       dec_div;

    dec_op_t    slot;
    logic       slot_div;
    logic [3:0] hilo_cnt;
    logic       hazard;
    logic       accept;
    logic       drain;

    mips_alu_issue_decode u_decode (
        .instr    (in_instr),
        .op       (dec_op),
        .illegal  (dec_illegal),
        .hilo_use (dec_hilo),
        .is_div   (dec_div)
    );

    // A divide still in the slot counts as outstanding even before its drain loads the counter
    assign hazard   = dec_hilo && ((hilo_cnt != 4'd0) || (out_valid && slot_div));
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Issue slot: load on a legal accept, empty when drained without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            slot      <= '0;
            slot_div  <= 1'b0;
        end else if (accept) begin
            out_valid <= !dec_illegal;
            if (!dec_illegal) begin
                slot     <= dec_op;
                slot_div <= dec_div;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // HI/LO busy counter starts when a divide leaves the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo_cnt <= 4'd0;
        end else if (drain && slot_div) begin
            hilo_cnt <= DIV_LAT_CNT;
        end else if (hilo_cnt != 4'd0) begin
            hilo_cnt <= hilo_cnt - 4'd1;
        end
    end

    // Single-cycle flag for a dropped undecodable word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && dec_illegal;
        end
    end

    assign out_funct   = slot.funct;
    assign out_rs      = slot.rs;
    assign out_rt      = slot.rt;
    assign out_a_src   = slot.a_src;
    assign out_b_src   = slot.b_src;
    assign out_imm     = slot.imm;
    assign out_wr_en   = slot.wr_en;
    assign out_wr_addr = slot.wr_addr;
    assign out_branch  = slot.branch;

endmodule
